// File: rtl/wptr_full_level.sv
// Write-domain pointer and status block for an asynchronous FIFO: binary/Gray write pointers,
// RAM write address, and registered full, almost-full, fill level and sticky overflow.
module wptr_full_level #(
  parameter int unsigned ADDR_SIZE    = 4,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic                 wclr_ovf,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 woverflow
);

  localparam int unsigned Depth = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AfullThresh = (ADDR_SIZE + 1)'(Depth - AFULL_MARGIN);

  logic [ADDR_SIZE:0] wbin_q, wbin_d;
  logic [ADDR_SIZE:0] wgray_q, wgray_d;
  logic [ADDR_SIZE:0] wlevel_q, wlevel_d;
  logic [ADDR_SIZE:0] rbin_s;
  logic               wfull_q, wfull_d;
  logic               wafull_q, wafull_d;
  logic               wovf_q, wovf_d;
  logic               accept;

  always_comb begin
    rbin_s = '0;
    rbin_s[ADDR_SIZE] = wq2_rptr[ADDR_SIZE];
    for (int i = int'(ADDR_SIZE) - 1; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
    end
  end

  always_comb begin
    accept  = winc & ~wfull_q;
    wbin_d  = wbin_q + {{ADDR_SIZE{1'b0}}, accept};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    // Full when the write pointer leads the read pointer by exactly one lap.
    wfull_d  = (wgray_d == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]});
    wlevel_d = wbin_d - rbin_s;
    wafull_d = (wlevel_d >= AfullThresh);
    // A rejected write in the same cycle overrides a clear request.
    if (winc & wfull_q) begin
      wovf_d = 1'b1;
    end else if (wclr_ovf) begin
      wovf_d = 1'b0;
    end else begin
      wovf_d = wovf_q;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDR_SIZE-1:0];
  assign wptr         = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed bench for wptr_full_level: a behavioural model pushes expected outputs into a
// scoreboard queue as each step is driven; entries are popped and checked after the edge.
module tb_wptr_full_level;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic       wclr_ovf = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       afull;
    logic [4:0] lvl;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  // Model state
  logic [4:0] m_wbin = '0;
  logic       m_full = 1'b0;
  logic       m_ovf  = 1'b0;

  wptr_full_level #(.ADDR_SIZE(4), .AFULL_MARGIN(2)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wclr_ovf     (wclr_ovf),
    .wq2_rptr     (wq2_rptr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] from_gray(input logic [4:0] g);
    logic [4:0] b;
    b = g;
    for (int k = 1; k < 5; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".waddr"}, 32'(waddr), 32'(e.waddr));
    check({tag, ".wptr"}, 32'(wptr), 32'(e.wptr));
    check({tag, ".wfull"}, 32'(wfull), 32'(e.full));
    check({tag, ".walmost_full"}, 32'(walmost_full), 32'(e.afull));
    check({tag, ".wlevel"}, 32'(wlevel), 32'(e.lvl));
    check({tag, ".woverflow"}, 32'(woverflow), 32'(e.ovf));
  endtask

  task automatic model_reset();
    m_wbin = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle of stimulus at the falling edge, predict, then check after the rising edge.
  task automatic step(input string tag, input logic inc, input logic clr, input logic [4:0] rg);
    exp_t       e;
    logic       acc;
    logic [4:0] nb;
    logic [4:0] lvl;
    @(negedge wclk);
    winc     = inc;
    wclr_ovf = clr;
    wq2_rptr = rg;
    acc = inc && !m_full;
    nb  = m_wbin + {4'b0, acc};
    lvl = nb - from_gray(rg);
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_wbin  = nb;
    m_full  = (lvl == 5'd16);
    e.waddr = nb[3:0];
    e.wptr  = to_gray(nb);
    e.full  = m_full;
    e.afull = (lvl >= 5'd14);
    e.lvl   = lvl;
    e.ovf   = m_ovf;
    sb.push_back(e);
    @(posedge wclk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      check_all(tag, sb.pop_front());
    end
  endtask

  initial begin
    exp_t zero;
    logic [4:0] rb;
    zero = '0;

    // Reset values
    #1;
    check_all("reset", zero);
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;

    // Fill to full
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 5'd0);
    check("fill.wptr_lit", 32'(wptr), 32'h18);
    check("fill.wfull_lit", 32'(wfull), 32'd1);
    check("fill.wlevel_lit", 32'(wlevel), 32'd16);

    // Overflow handling
    for (int i = 0; i < 3; i++) step("ovf", 1'b1, 1'b0, 5'd0);
    check("ovf.sticky_lit", 32'(woverflow), 32'd1);
    step("ovf_clr", 1'b0, 1'b1, 5'd0);
    check("ovf_clr_lit", 32'(woverflow), 32'd0);
    step("ovf_set", 1'b1, 1'b0, 5'd0);
    step("ovf_both", 1'b1, 1'b1, 5'd0);
    check("ovf_both_lit", 32'(woverflow), 32'd1);

    // Read progress becomes visible
    step("drain", 1'b0, 1'b0, 5'b00001);
    check("drain.wlevel_lit", 32'(wlevel), 32'd15);
    check("drain.wfull_lit", 32'(wfull), 32'd0);
    check("drain.afull_lit", 32'(walmost_full), 32'd1);
    step("refill", 1'b1, 1'b0, 5'b00001);
    check("refill.wfull_lit", 32'(wfull), 32'd1);

    // Asynchronous reset while full, away from any clock edge
    @(posedge wclk);
    #3;
    wrst_n = 1'b0;
    #1;
    check_all("async_rst", zero);
    model_reset();
    winc = 1'b0;
    wclr_ovf = 1'b0;
    wq2_rptr = '0;
    @(negedge wclk);
    wrst_n = 1'b1;

    // Wrap-around with the read pointer trailing by two
    step("wrap_pre", 1'b1, 1'b0, 5'd0);
    step("wrap_pre", 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 34; i++) step("wrap", 1'b1, 1'b0, to_gray(m_wbin - 5'd1));
    check("wrap.wlevel_lit", 32'(wlevel), 32'd2);
    check("wrap.waddr_lit", 32'(waddr), 32'd4);

    // Simultaneous write and read advance at level 15
    rb = m_wbin - 5'd15;
    step("sim_pre", 1'b0, 1'b0, to_gray(rb));
    check("sim_pre.wlevel_lit", 32'(wlevel), 32'd15);
    step("sim", 1'b1, 1'b0, to_gray(rb + 5'd1));
    check("sim.wlevel_lit", 32'(wlevel), 32'd15);
    check("sim.wfull_lit", 32'(wfull), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
